// File: rtl/prog_loader_pkg.sv
// loader_pkg: shared types and constants for the boot-time program loader.
//   - state_t      : loader FSM states (S_CSUM only exists with LOADER_CHECKSUM_EN)
//   - HDR_BYTES    : header length in bytes (count[15:0], pc[15:0])
//   - LOADER_ADDR_W / LOADER_DATA_W : default memory geometry
//   - CSUM_INIT    : seed of the running payload XOR
//   - hdr_bad()    : header legality check (count range, pc range)
// Optional feature macro: LOADER_CHECKSUM_EN
package loader_pkg;

  localparam int         HDR_BYTES     = 4;
  localparam int         LOADER_ADDR_W = 11;
  localparam int         LOADER_DATA_W = 32;
  localparam logic [7:0] CSUM_INIT     = 8'h00;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [3:0] {
    S_CNT0 = 4'd0,
    S_CNT1 = 4'd1,
    S_PC0  = 4'd2,
    S_PC1  = 4'd3,
    S_DATA = 4'd4,
    S_WR   = 4'd5,
    S_CSUM = 4'd6,
    S_DONE = 4'd7,
    S_ERR  = 4'd8
  } state_t;
`else
  typedef enum logic [3:0] {
    S_CNT0 = 4'd0,
    S_CNT1 = 4'd1,
    S_PC0  = 4'd2,
    S_PC1  = 4'd3,
    S_DATA = 4'd4,
    S_WR   = 4'd5,
    S_DONE = 4'd7,
    S_ERR  = 4'd8
  } state_t;
`endif

  // A header is illegal when the word count exceeds the memory depth
  // or the start PC has bits set above the word-address width.
  function automatic logic hdr_bad(input logic [15:0] count,
                                   input logic [15:0] pc,
                                   input int          addr_w);
    logic [31:0] depth;
    depth = 32'd1 << addr_w;
    return ({16'd0, count} > depth) || (({16'd0, pc} >> addr_w) != 32'd0);
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if: byte-stream input and memory port A of the program loader.
//   in_valid/in_data/in_ready : byte stream (valid/ready)
//   mem_wren/mem_addr/mem_data: write side of instruction memory port A
// Modports: master = loader side, slave = stream source / memory side.
interface prog_loader_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_wren;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;

  modport master (
    input  in_valid, in_data,
    output in_ready, mem_wren, mem_addr, mem_data
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, mem_wren, mem_addr, mem_data
  );
endinterface

// File: rtl/prog_loader_byte_packer.sv
// byte_packer: packs bytes little-endian into a DATA_W word.
//   clk, rst_n : clock, async active-low reset
//   clr        : discard partial word, restart at lane 0
//   en         : byte_in is consumed this cycle
//   byte_in    : byte to insert at the current lane
//   word       : stored partial word with byte_in already inserted (when en)
//   word_full  : en on the last lane; word is then complete
module byte_packer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [7:0]        byte_in,
  output logic [DATA_W-1:0] word,
  output logic              word_full
);
  localparam int LANES  = DATA_W / 8;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  logic [LANE_W-1:0] lane_r;
  logic [DATA_W-1:0] acc_r;

  // Insert the incoming byte into its lane; flag the final lane.
  always_comb begin
    word      = acc_r;
    word_full = 1'b0;
    if (en) begin
      word[int'(lane_r)*8 +: 8] = byte_in;
      word_full = (lane_r == LANE_W'(LANES - 1));
    end else begin
      word      = acc_r;
      word_full = 1'b0;
    end
  end

  // Lane counter and partial-word accumulator; cleared once a word completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_r <= '0;
      acc_r  <= '0;
    end else if (clr) begin
      lane_r <= '0;
      acc_r  <= '0;
    end else if (en) begin
      if (word_full) begin
        lane_r <= '0;
        acc_r  <= '0;
      end else begin
        lane_r <= lane_r + LANE_W'(1);
        acc_r  <= word;
      end
    end
  end
endmodule

// File: rtl/prog_loader.sv
// prog_loader: boot-time loader. Parses a 4-byte header (count, start PC),
// writes count little-endian packed words to memory port A at addresses
// 0..count-1, then releases the CPU with the received start PC.
//   clk, rst_n : clock, async active-low reset
//   bus        : prog_loader_if.master (byte stream in, memory port A out)
//   cpu_rst_n  : CPU reset, low until the load completes
//   start_pc   : PC handed to the CPU on release
//   done       : load complete
//   err        : malformed stream, CPU held in reset until rst_n
// Optional feature macro: LOADER_CHECKSUM_EN (trailing XOR checksum byte).
module prog_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = LOADER_ADDR_W,
  parameter int DATA_W = LOADER_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  prog_loader_if.master     bus,
  output logic              cpu_rst_n,
  output logic [ADDR_W-1:0] start_pc,
  output logic              done,
  output logic              err
);
`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_END = S_CSUM;
`else
  localparam state_t S_END = S_DONE;
`endif

  state_t            state_r, state_s;
  logic [15:0]       count_r, count_s;
  logic [15:0]       pc_r, pc_s;
  logic [ADDR_W:0]   idx_r, idx_s;
  logic              accept_s;
  logic              ready_s;
  logic              pk_clr_s, pk_en_s, pk_full_s;
  logic [DATA_W-1:0] pk_word_s;

  logic              in_ready_r, mem_wren_r, cpu_rst_n_r, done_r, err_r;
  logic [ADDR_W-1:0] mem_addr_r, start_pc_r;
  logic [DATA_W-1:0] mem_data_r;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum_r, csum_s;
`endif

  assign accept_s = bus.in_valid && in_ready_r;

  byte_packer #(.DATA_W(DATA_W)) u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (pk_clr_s),
    .en       (pk_en_s),
    .byte_in  (bus.in_data),
    .word     (pk_word_s),
    .word_full(pk_full_s)
  );

  // Next-state and header/index bookkeeping.
  always_comb begin
    state_s  = state_r;
    count_s  = count_r;
    pc_s     = pc_r;
    idx_s    = idx_r;
    pk_clr_s = 1'b0;
    pk_en_s  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_s   = csum_r;
`endif
    case (state_r)
      S_CNT0: begin
        if (accept_s) begin
          count_s[7:0] = bus.in_data;
          state_s      = S_CNT1;
        end else begin
          state_s = state_r;
        end
      end
      S_CNT1: begin
        if (accept_s) begin
          count_s[15:8] = bus.in_data;
          state_s       = S_PC0;
        end else begin
          state_s = state_r;
        end
      end
      S_PC0: begin
        if (accept_s) begin
          pc_s[7:0] = bus.in_data;
          state_s   = S_PC1;
        end else begin
          state_s = state_r;
        end
      end
      S_PC1: begin
        if (accept_s) begin
          pc_s[15:8] = bus.in_data;
          idx_s      = '0;
          pk_clr_s   = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          csum_s     = CSUM_INIT;
`endif
          if (hdr_bad(count_r, pc_s, ADDR_W)) begin
            state_s = S_ERR;
          end else if (count_r == 16'd0) begin
            state_s = S_END;
          end else begin
            state_s = S_DATA;
          end
        end else begin
          state_s = state_r;
        end
      end
      S_DATA: begin
        if (accept_s) begin
          pk_en_s = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          csum_s  = csum_r ^ bus.in_data;
`endif
          if (pk_full_s) begin
            state_s = S_WR;
          end else begin
            state_s = state_r;
          end
        end else begin
          state_s = state_r;
        end
      end
      S_WR: begin
        // Index is one bit wider than the address so count == depth ends cleanly.
        idx_s = idx_r + (ADDR_W + 1)'(1);
        if (32'(idx_s) == 32'(count_r)) begin
          state_s = S_END;
        end else begin
          state_s = S_DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (accept_s) begin
          if (bus.in_data == csum_r) begin
            state_s = S_DONE;
          end else begin
            state_s = S_ERR;
          end
        end else begin
          state_s = state_r;
        end
      end
`endif
      S_DONE:  state_s = S_DONE;
      S_ERR:   state_s = S_ERR;
      default: state_s = S_ERR;
    endcase
  end

  // Stream acceptance is allowed in the header, data and checksum states.
  always_comb begin
    ready_s = 1'b0;
    case (state_s)
      S_CNT0, S_CNT1, S_PC0, S_PC1, S_DATA: ready_s = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CSUM:                               ready_s = 1'b1;
`endif
      default:                              ready_s = 1'b0;
    endcase
  end

  // FSM state and header/index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_CNT0;
      count_r <= 16'd0;
      pc_r    <= 16'd0;
      idx_r   <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_r  <= CSUM_INIT;
`endif
    end else begin
      state_r <= state_s;
      count_r <= count_s;
      pc_r    <= pc_s;
      idx_r   <= idx_s;
`ifdef LOADER_CHECKSUM_EN
      csum_r  <= csum_s;
`endif
    end
  end

  // Registered outputs, decoded from the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b0;
      mem_wren_r  <= 1'b0;
      mem_addr_r  <= '0;
      mem_data_r  <= '0;
      cpu_rst_n_r <= 1'b0;
      start_pc_r  <= '0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      in_ready_r  <= ready_s;
      mem_wren_r  <= (state_s == S_WR);
      cpu_rst_n_r <= (state_s == S_DONE);
      done_r      <= (state_s == S_DONE);
      err_r       <= (state_s == S_ERR);
      if (state_s == S_WR) begin
        mem_addr_r <= idx_r[ADDR_W-1:0];
        mem_data_r <= pk_word_s;
      end
      if ((state_s == S_DONE) && (state_r != S_DONE)) begin
        start_pc_r <= pc_s[ADDR_W-1:0];
      end
    end
  end

  assign bus.in_ready = in_ready_r;
  assign bus.mem_wren = mem_wren_r;
  assign bus.mem_addr = mem_addr_r;
  assign bus.mem_data = mem_data_r;
  assign cpu_rst_n    = cpu_rst_n_r;
  assign start_pc     = start_pc_r;
  assign done         = done_r;
  assign err          = err_r;
endmodule
